// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads instruction words from memory and hands them to the decoder
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        mem_address,
    output logic               mem_enable,
    output logic               mem_read_write,
    input  logic [31:0]        mem_data_out,
    input  logic               mem_busy,
    output logic [31:0]        instr_out,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault,
    output logic [COUNT_W-1:0] fetch_count
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, FAULT} state_t;

    state_t      state, nxt, resume;
    logic [31:0] pc, pc_d;
    logic        drop, drop_d, take, accept, aligned, outstanding, landing;

    assign mem_address    = pc;
    assign mem_read_write = 1'b1;
    assign aligned        = redirect_pc[1:0] == 2'b00;
    assign resume         = fetch_en ? REQ : IDLE;
    assign outstanding    = state == REQ || state == WAIT;
    assign landing        = state == WAIT && !mem_busy;

    // Next-state decision; a redirect outranks every normal transition
    always_comb begin
        nxt    = state;
        pc_d   = pc;
        drop_d = drop;
        take   = 1'b0;
        accept = 1'b0;
        if (redirect_en && !aligned) begin
            nxt    = FAULT;
            drop_d = 1'b0;
        end else if (redirect_en) begin
            pc_d   = redirect_pc;
            drop_d = outstanding && !landing;
            nxt    = drop_d ? WAIT : resume;
        end else begin
            case (state)
                IDLE:  nxt = resume;
                REQ:   nxt = WAIT;
                WAIT:  if (!mem_busy) begin
                    take   = !drop;
                    drop_d = 1'b0;
                    pc_d   = drop ? pc : pc + 32'd4;
                    nxt    = drop ? resume : VALID;
                end
                VALID: if (instr_ready) begin
                    accept = 1'b1;
                    nxt    = resume;
                end
                default: nxt = FAULT;
            endcase
        end
    end

    // State, PC and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_out   <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
            mem_enable  <= 1'b0;
        end else begin
            state       <= nxt;
            pc          <= pc_d;
            drop        <= drop_d;
            instr_valid <= nxt == VALID;
            fetch_fault <= nxt == FAULT;
            mem_enable  <= nxt == REQ || nxt == WAIT;
            if (take) begin
                instr_out <= mem_data_out;
                instr_pc  <= pc;
            end
            if (accept) fetch_count <= fetch_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a reference instruction-stream model for fetch_unit
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset, fetch_en, redirect_en, instr_ready;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address, mem_data_out, instr_out, instr_pc;
    logic        mem_enable, mem_read_write, mem_busy, instr_valid, fetch_fault;
    logic [15:0] fetch_count;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int busy_len = 0;
    int bcnt = 0;

    logic [31:0] m_pc;
    logic [15:0] m_count;
    logic        m_fault;

    fetch_unit dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .mem_address(mem_address), .mem_enable(mem_enable),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out),
        .mem_busy(mem_busy), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: busy for busy_len cycles after the request, garbage data while busy
    assign mem_busy     = mem_enable && (bcnt <= busy_len);
    assign mem_data_out = mem_busy ? 32'hDEAD_BEEF : word_at(mem_address);

    always #5 clock = ~clock;

    // Cycle counter and memory wait-state counter
    always @(posedge clock) begin
        cyc  <= cyc + 1;
        bcnt <= mem_enable ? bcnt + 1 : 0;
    end

    // Reference model: expected next delivered PC, accepted count and fault flag
    always @(posedge clock) begin
        if (reset) begin
            m_pc    <= 32'h8002_0000;
            m_count <= 16'd0;
            m_fault <= 1'b0;
        end else if (redirect_en) begin
            m_fault <= redirect_pc[1:0] != 2'b00;
            if (redirect_pc[1:0] == 2'b00) m_pc <= redirect_pc;
        end else if (instr_valid && instr_ready) begin
            m_count <= m_count + 16'd1;
            m_pc    <= m_pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Compare DUT against the model every cycle outside reset
    always @(negedge clock) begin
        if (!reset) begin
            chk("model count", 32'(fetch_count), 32'(m_count));
            chk("model fault", 32'(fetch_fault), 32'(m_fault));
            if (instr_valid) begin
                chk("model pc", instr_pc, m_pc);
                chk("model word", instr_out, word_at(m_pc));
            end
            if (mem_enable) chk("read_write", 32'(mem_read_write), 32'd1);
            if (fetch_fault) chk("fault quiet", 32'({instr_valid, mem_enable}), 32'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] epc, input logic [31:0] ew, output int at);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            seen = instr_valid;
        end
        at = cyc;
        chk({name, " valid"}, 32'(seen), 32'd1);
        chk({name, " pc"}, instr_pc, epc);
        chk({name, " word"}, instr_out, ew);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        step();
        redirect_en = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, " addr"}, mem_address, 32'h8002_0000);
        chk({name, " valid"}, 32'(instr_valid), 32'd0);
        chk({name, " fault"}, 32'(fetch_fault), 32'd0);
        chk({name, " count"}, 32'(fetch_count), 32'd0);
        chk({name, " enable"}, 32'(mem_enable), 32'd0);
    endtask

    initial begin
        int a1, a2, a3, c0;
        reset = 1'b1; fetch_en = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        check_reset_state("reset");

        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_valid("A", 32'h8002_0000, 32'h9355_9BDF, a1);
        wait_valid("B", 32'h8002_0004, 32'h9355_9BDB, a2);
        wait_valid("C", 32'h8002_0008, 32'h9355_9BD7, a3);
        fetch_en = 1'b0;
        chk("spacing AB", 32'(a2 - a1), 32'd3);
        chk("spacing BC", 32'(a3 - a2), 32'd3);
        step();
        chk("count 3", 32'(fetch_count), 32'd3);
        chk("park idle", 32'(mem_enable), 32'd0);

        fetch_en = 1'b1; instr_ready = 1'b0;
        wait_valid("stall", 32'h8002_000C, 32'h9355_9BD3, a1);
        repeat (5) begin
            step();
            chk("stall valid", 32'(instr_valid), 32'd1);
            chk("stall pc", instr_pc, 32'h8002_000C);
            chk("stall word", instr_out, 32'h9355_9BD3);
            chk("stall enable", 32'(mem_enable), 32'd0);
            chk("stall count", 32'(fetch_count), 32'd3);
        end
        instr_ready = 1'b1;
        step();
        chk("count 4", 32'(fetch_count), 32'd4);

        busy_len = 4;
        c0 = cyc;
        wait_valid("busy", 32'h8002_0010, 32'h9355_9BCF, a1);
        chk("busy latency", 32'(a1 - c0), 32'd6);

        busy_len = 3;
        step();
        step();
        chk("in wait", 32'(mem_enable), 32'd1);
        pulse_redirect(32'h8002_0100);
        wait_valid("redirect", 32'h8002_0100, 32'h9355_9ADF, a1);

        pulse_redirect(32'h8002_0102);
        chk("misalign fault", 32'(fetch_fault), 32'd1);
        chk("misalign valid", 32'(instr_valid), 32'd0);
        chk("misalign no count", 32'(fetch_count), 32'd5);
        repeat (3) begin
            step();
            chk("fault hold", 32'({fetch_fault, mem_enable}), 32'd2);
        end
        pulse_redirect(32'h8002_0200);
        chk("fault clear", 32'(fetch_fault), 32'd0);
        wait_valid("recover", 32'h8002_0200, 32'h9355_99DF, a1);
        step();
        chk("count 6", 32'(fetch_count), 32'd6);
        step();
        chk("wait before reset", 32'(mem_enable), 32'd1);
        reset = 1'b1; fetch_en = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        check_reset_state("mid reset");

        busy_len = 0; fetch_en = 1'b1; instr_ready = 1'b1;
        pulse_redirect(32'hFFFF_FFFC);
        wait_valid("top", 32'hFFFF_FFFC, 32'hECA8_6423, a1);
        wait_valid("wrap", 32'h0000_0000, 32'h1357_9BDF, a2);
        fetch_en = 1'b0;
        step();
        chk("wrap count", 32'(fetch_count), 32'd2);
        chk("wrap fault", 32'(fetch_fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
